// File: rtl/adder_pkg.sv
// Shared parameter helpers for the pipelined carry-lookahead adder/subtractor.
// Slice and group geometry are derived here so every user agrees on the split.
package adder_pkg;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int ngroups(input int width, input int stages, input int group);
    return width / (stages * group);
  endfunction

  function automatic bit params_legal(input int width, input int group, input int stages);
    bit stages_ok;
    stages_ok = (stages == 1) || (stages == 2) || (stages == 4) || (stages == 8);
    return stages_ok && (group > 0) && (width > 0) && ((width % (stages * group)) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead block: per-bit sums from cin, plus group generate/propagate
// that do not depend on cin so the second lookahead level can run in parallel.
module cla_group #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] gen_s;
  logic [GROUP-1:0] prop_s;
  logic [GROUP-1:0] carry_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Every bit carry is a flat sum of products over the bits below it.
  always_comb begin
    logic any_g;
    logic run_p;
    carry_s = '0;
    any_g   = 1'b0;
    run_p   = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      any_g = 1'b0;
      run_p = 1'b1;
      for (int m = i - 1; m >= 0; m--) begin
        any_g = any_g | (gen_s[m] & run_p);
        run_p = run_p & prop_s[m];
      end
      carry_s[i] = any_g | (cin & run_p);
    end
  end

  // Group generate is kept in its own block so it has no dependence on cin.
  always_comb begin
    logic run_p;
    g     = 1'b0;
    run_p = 1'b1;
    for (int m = GROUP - 1; m >= 0; m--) begin
      g     = g | (gen_s[m] & run_p);
      run_p = run_p & prop_s[m];
    end
  end

  assign p   = &prop_s;
  assign sum = prop_s ^ carry_s;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: operands are registered on acceptance,
// then slice k is resolved in stage k and its carry is registered for slice k+1.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SLICE_W = slice_w(WIDTH, STAGES);
  localparam int NGROUPS = ngroups(WIDTH, STAGES, GROUP);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE_W{1'b1}});

  if (!params_legal(WIDTH, GROUP, STAGES)) begin : g_bad_params
    $error("pipelined_cla_adder: illegal WIDTH/GROUP/STAGES combination");
  end

  // Level 0 holds the accepted operands; level k+1 holds the result of slice k.
  logic             valid_q [STAGES+1];
  logic [WIDTH-1:0] a_q     [STAGES+1];
  logic [WIDTH-1:0] b_q     [STAGES+1];
  logic [WIDTH-1:0] sum_q   [STAGES+1];
  logic             c_q     [STAGES+1];
  logic             ovf_q;

  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_d;
  logic             advance_s;

  assign advance_s = !valid_q[STAGES] || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [NGROUPS-1:0] grp_g_s;
    logic [NGROUPS-1:0] grp_p_s;
    logic [NGROUPS:0]   grp_c_s;
    logic [SLICE_W-1:0] slice_sum_s;

    for (genvar j = 0; j < NGROUPS; j++) begin : g_grp
      cla_group #(
        .GROUP(GROUP)
      ) u_grp (
        .a   (a_q[k][k*SLICE_W + j*GROUP +: GROUP]),
        .b   (b_q[k][k*SLICE_W + j*GROUP +: GROUP]),
        .cin (grp_c_s[j]),
        .sum (slice_sum_s[j*GROUP +: GROUP]),
        .g   (grp_g_s[j]),
        .p   (grp_p_s[j])
      );
    end

    // Second-level lookahead: each group carry is formed directly from group G/P.
    always_comb begin
      logic any_g;
      logic run_p;
      grp_c_s = '0;
      any_g   = 1'b0;
      run_p   = 1'b1;
      for (int i = 0; i <= NGROUPS; i++) begin
        any_g = 1'b0;
        run_p = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          any_g = any_g | (grp_g_s[m] & run_p);
          run_p = run_p & grp_p_s[m];
        end
        grp_c_s[i] = any_g | (c_q[k] & run_p);
      end
    end

    assign sum_d[k] = (sum_q[k] & ~(SLICE_MASK << (k*SLICE_W)))
                    | (WIDTH'(slice_sum_s) << (k*SLICE_W));
    assign c_d[k]   = grp_c_s[NGROUPS];
  end

  // Carry into the MSB is recovered from the MSB operand and sum bits.
  assign ovf_d = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
               ^ sum_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];

  // Pipeline registers; the whole pipe freezes while the output is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        c_q[k]     <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance_s) begin
      valid_q[0] <= in_valid;
      a_q[0]     <= a;
      b_q[0]     <= b ^ {WIDTH{sub}};
      sum_q[0]   <= '0;
      c_q[0]     <= carry_in ^ sub;
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k+1] <= valid_q[k];
        a_q[k+1]     <= a_q[k];
        b_q[k+1]     <= b_q[k];
        sum_q[k+1]   <= sum_d[k];
        c_q[k+1]     <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES];
  assign sum       = sum_q[STAGES];
  assign carry_out = c_q[STAGES];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: four adders (STAGES 1, 2, 4, 8) share one stimulus stream; each
// acceptance pushes the expected result, and a negedge monitor pops and compares.
module tb_pipelined_cla_adder;

  localparam int W  = 32;
  localparam int ND = 4;

  function automatic int stg_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int grp_of(input int i);
    return (stg_of(i) == 8) ? 4 : 8;
  endfunction

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int unsigned  acc;
    int unsigned  stl;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          cin;
  logic [ND-1:0] in_ready;
  logic [ND-1:0] out_valid;
  logic [ND-1:0] cout;
  logic [ND-1:0] ovf;
  logic [W-1:0]  dut_sum [ND];

  logic [W-1:0]  e_sum;
  logic          e_c;
  logic          e_v;

  int            checks = 0;
  int            errors = 0;
  int unsigned   cyc = 0;
  int unsigned   stall_cnt [ND];
  bit            head_seen [ND];
  exp_t          sbq [ND][$];
  vec_t          vecs [11];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pipelined_cla_adder #(
      .WIDTH (W),
      .GROUP (grp_of(g)),
      .STAGES(stg_of(g))
    ) u_dut (
      .clock    (clk),
      .reset_n  (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .carry_in (cin),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .sum      (dut_sum[g]),
      .carry_out(cout[g]),
      .overflow (ovf[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub, input logic mcin);
    logic [W-1:0] be;
    logic [W:0]   t;
    logic         v;
    be = msub ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, mcin ^ msub};
    v  = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
    return {t[W-1:0], t[W], v};
  endfunction

  function automatic bit pending();
    for (int i = 0; i < ND; i++) begin
      if (sbq[i].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor: compare head of each scoreboard, record acceptances, count stalls.
  always @(negedge clk) begin
    exp_t        hd;
    exp_t        ne;
    int unsigned want;
    if (rst_n) begin
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (in_ready[i] !== (!out_valid[i] || out_ready)) begin
          errors++;
          $display("FAIL in_ready dut%0d: got %b want %b", i, in_ready[i], !out_valid[i] || out_ready);
        end
        if (out_valid[i]) begin
          if (sbq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output dut%0d: got sum=%h with nothing pending", i, dut_sum[i]);
          end else begin
            hd = sbq[i][0];
            if (!head_seen[i]) begin
              want = hd.acc + stg_of(i) + (stall_cnt[i] - hd.stl);
              checks++;
              if (cyc != want) begin
                errors++;
                $display("FAIL latency dut%0d: appeared after edge %0d want edge %0d", i, cyc, want);
              end
              head_seen[i] = 1'b1;
            end
            checks++;
            if ({dut_sum[i], cout[i], ovf[i]} !== {hd.s, hd.c, hd.v}) begin
              errors++;
              $display("FAIL result dut%0d: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                       i, dut_sum[i], cout[i], ovf[i], hd.s, hd.c, hd.v);
            end
            if (out_ready) begin
              hd = sbq[i].pop_front();
              head_seen[i] = 1'b0;
            end
          end
        end
        if (in_valid && in_ready[i]) begin
          ne.s   = e_sum;
          ne.c   = e_c;
          ne.v   = e_v;
          ne.acc = cyc + 1;
          ne.stl = stall_cnt[i];
          sbq[i].push_back(ne);
        end
        if (out_valid[i] && !out_ready) stall_cnt[i]++;
      end
    end
  end

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                       input logic tcin, input logic [W-1:0] ts, input logic tc, input logic tv);
    @(posedge clk);
    #1;
    a = ta; b = tb; sub = tsub; cin = tcin;
    e_sum = ts; e_c = tc; e_v = tv;
    in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rc;
    logic [W+1:0] m;
    ra = $urandom; rb = $urandom;
    rs = 1'($urandom_range(0, 1));
    rc = 1'($urandom_range(0, 1));
    m  = model(ra, rb, rs, rc);
    drive(ra, rb, rs, rc, m[W+1:2], m[1], m[0]);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (pending() && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL drain_%s: results still pending after %0d cycles, want none", name, n);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if ({out_valid[i], dut_sum[i], cout[i], ovf[i]} !== '0) begin
        errors++;
        $display("FAIL reset_%s dut%0d: got v=%b sum=%h c=%b o=%b want all zero",
                 name, i, out_valid[i], dut_sum[i], cout[i], ovf[i]);
      end
    end
  endtask

  initial begin
    vecs = '{
      '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
      '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
      '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0},
      '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0},
      '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0},
      '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1},
      '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0},
      '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0},
      '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0},
      '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1},
      '{32'h00FF00FF, 32'hFF00FF01, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}
    };
    for (int i = 0; i < ND; i++) begin
      stall_cnt[i] = 0;
      head_seen[i] = 1'b0;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    e_sum = '0; e_c = 1'b0; e_v = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("initial");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors, spaced out, then back to back.
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].a, vecs[k].b, vecs[k].sub, vecs[k].cin, vecs[k].s, vecs[k].c, vecs[k].v);
      idle();
    end
    drain("directed_spaced");
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].a, vecs[k].b, vecs[k].sub, vecs[k].cin, vecs[k].s, vecs[k].c, vecs[k].v);
    end
    idle();
    drain("directed_stream");

    // 100-bundle stream with the cross-slice carry case embedded.
    for (int k = 0; k < 100; k++) begin
      if (k == 37) drive(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
      else         drive_rand();
    end
    idle();
    drain("stream");

    // Backpressure: stall 5 cycles while a new bundle is held on the input.
    for (int k = 0; k < 12; k++) drive_rand();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    a = 32'h0000FFFF; b = 32'h00000001; sub = 1'b0; cin = 1'b1;
    e_sum = 32'h00010001; e_c = 1'b0; e_v = 1'b0;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    idle();
    drain("backpressure");

    // Asynchronous reset with bundles in flight, then a single bundle afterwards.
    for (int k = 0; k < 10; k++) drive_rand();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1 check_reset_state("midop");
    for (int i = 0; i < ND; i++) begin
      sbq[i].delete();
      head_seen[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    idle();
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
